// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply, restoring divide, one op in flight.
// Build option: MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle '*' product.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr,
    input  logic            flush,
    output logic            busy,
    output logic            stall_req,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic [1:0]      dbg_state
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_op;
    logic [4:0]          r_rd;
    logic [XLEN-1:0]     r_b;
    logic [2*XLEN-1:0]   r_acc;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_resp_valid;
    logic [XLEN-1:0]     r_resp_data;
    logic [4:0]          r_resp_rd;

    // Handshake: a request transfers on a clock edge where req_valid && req_ready && !flush;
    // req_ready is high only in IDLE, and the requester holds its request until it transfers.
    logic            w_accept;
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_div_ovf;

    assign w_accept   = req_valid && (r_state == S_IDLE) && !flush;
    assign w_is_div   = req_op[2];
    assign w_a_signed = (req_op == 3'd1) || (req_op == 3'd2) || (req_op == 3'd4) || (req_op == 3'd6);
    assign w_b_signed = (req_op == 3'd1) || (req_op == 3'd4) || (req_op == 3'd6);
    assign w_a_neg    = w_a_signed && rs1_data[XLEN-1];
    assign w_b_neg    = w_b_signed && rs2_data[XLEN-1];
    assign w_a_mag    = w_a_neg ? (XLEN'(0) - rs1_data) : rs1_data;
    assign w_b_mag    = w_b_neg ? (XLEN'(0) - rs2_data) : rs2_data;
    assign w_div_zero = w_is_div && (rs2_data == '0);
    assign w_div_ovf  = w_is_div && w_b_signed && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                        && (rs2_data == {XLEN{1'b1}});

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_a_ext;
    logic [2*XLEN-1:0] w_b_ext;
    logic [2*XLEN-1:0] w_fast_prod;

    assign w_a_ext     = {{XLEN{w_a_signed && rs1_data[XLEN-1]}}, rs1_data};
    assign w_b_ext     = {{XLEN{w_b_signed && rs2_data[XLEN-1]}}, rs2_data};
    assign w_fast_prod = w_a_ext * w_b_ext;
`endif

    // The accumulator low half holds the multiplier / dividend magnitude; r_b the other operand.
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN-1:0]   w_trial;
    logic              w_fits;
    logic [2*XLEN-1:0] w_div_next;

    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_fits     = (w_rem_sh >= {1'b0, r_b});
    assign w_trial    = w_rem_sh[XLEN-1:0] - r_b;
    assign w_div_next = {(w_fits ? w_trial : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_fits};

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_result;

    assign w_prod = r_neg_q ? ((2*XLEN)'(0) - r_acc) : r_acc;
    assign w_quo  = r_neg_q ? (XLEN'(0) - r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
    assign w_rem  = r_neg_r ? (XLEN'(0) - r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_result = w_rem;
        case (r_op)
            3'd0:                 w_result = w_prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:     w_result = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:           w_result = w_quo;
            default:              w_result = w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_op         <= '0;
            r_rd         <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_rd    <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            if (flush) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_op    <= req_op;
                            r_rd    <= rd_addr;
                            r_b     <= w_b_mag;
                            r_cnt   <= CNT_W'(XLEN-1);
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_acc   <= {{XLEN{1'b0}}, w_a_mag};
                            r_state <= S_CALC;
                            // Early-out results are preloaded as {remainder, quotient}, no fix-up.
                            if (w_div_zero) begin
                                r_acc   <= {rs1_data, {XLEN{1'b1}}};
                                r_neg_q <= 1'b0;
                                r_neg_r <= 1'b0;
                                r_state <= S_DONE;
                            end else if (w_div_ovf) begin
                                r_acc   <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                                r_neg_q <= 1'b0;
                                r_neg_r <= 1'b0;
                                r_state <= S_DONE;
                            end
`ifdef MULDIV_FAST_MUL_EN
                            if (!w_is_div) begin
                                r_acc   <= w_fast_prod;
                                r_neg_q <= 1'b0;
                                r_neg_r <= 1'b0;
                                r_state <= S_DONE;
                            end
`endif
                        end
                    end
                    S_CALC: begin
                        r_acc <= r_op[2] ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == '0) begin
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= w_result;
                        r_resp_rd    <= r_rd;
                        r_state      <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign stall_req  = ((r_state == S_IDLE) && req_valid) || (r_state == S_CALC) || (r_state == S_DONE);
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_rd    = r_resp_rd;
    assign dbg_state  = r_state;

endmodule
